// File: rtl/uart_tx_arbiter_pkg.sv
// Shared state encoding, default timing and index helpers for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StLaunch   = 2'd1,
    StWaitDone = 2'd2,
    StGap      = 2'd3
  } arb_state_e;

  localparam int unsigned DefaultGapCycles     = 3;
  localparam int unsigned DefaultLaunchTimeout = 15;

  // Increment modulo n; n need not be a power of two.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin select with lock override; lowest valid index at/after ptr wins.
module uart_tx_arbiter_rr #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IdxW-1:0]  ptr,
  input  logic             lock,
  input  logic [IdxW-1:0]  lock_id,
  output logic [N_REQ-1:0] grant_oh,
  output logic [IdxW-1:0]  grant_idx,
  output logic             grant_vld
);

  always_comb begin
    int unsigned j;
    j         = 0;
    grant_idx = lock_id;
    grant_vld = lock;
    if (!lock) begin
      grant_idx = '0;
      // Scan from farthest to nearest so the nearest valid offset is the final winner.
      for (int i = N_REQ - 1; i >= 0; i--) begin
        j = (32'(ptr) + 32'(i)) % N_REQ;
        if (req_valid[j[IdxW-1:0]]) begin
          grant_idx = j[IdxW-1:0];
          grant_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      grant_oh[k] = grant_vld && (grant_idx == IdxW'(k));
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_send between N_REQ byte sources: round-robin with packet lock, and the
// enable/busy handshake with a guard gap so every byte gets a fresh uart_en rising edge.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned GAP_CYCLES     = DefaultGapCycles,
  parameter int unsigned LAUNCH_TIMEOUT = DefaultLaunchTimeout,
  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               uart_en,
  output logic [7:0]         uart_din,
  input  logic               uart_tx_busy,
  output logic [IdxW-1:0]    grant_id,
  output logic               arb_busy,
  output logic               err_timeout
);

  localparam int unsigned CntMax = (LAUNCH_TIMEOUT > GAP_CYCLES) ? LAUNCH_TIMEOUT : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] LaunchLast = CntW'(LAUNCH_TIMEOUT - 1);
  localparam logic [CntW-1:0] GapLast    = CntW'(GAP_CYCLES - 1);

  arb_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] lock_id_q, lock_id_d;
  logic [IdxW-1:0] grant_id_q, grant_id_d;
  logic            lock_q, lock_d;
  logic [7:0]      din_q, din_d;
  logic            err_q, err_d;

  logic [N_REQ-1:0] cand_oh;
  logic [IdxW-1:0]  cand_idx;
  logic             cand_vld;
  logic [7:0]       cand_data;
  logic             cand_last;
  logic             accept;

  uart_tx_arbiter_rr #(
    .N_REQ(N_REQ)
  ) u_rr (
    .req_valid(req_valid),
    .ptr      (ptr_q),
    .lock     (lock_q),
    .lock_id  (lock_id_q),
    .grant_oh (cand_oh),
    .grant_idx(cand_idx),
    .grant_vld(cand_vld)
  );

  always_comb begin
    cand_data = '0;
    cand_last = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (cand_oh[k]) begin
        cand_data = req_data[8*k +: 8];
        cand_last = req_last[k];
      end
    end
  end

  assign accept = |(req_valid & req_ready);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_id_q  <= '0;
      grant_id_q <= '0;
      din_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_id_q  <= lock_id_d;
      grant_id_q <= grant_id_d;
      din_q      <= din_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_id_d  = lock_id_q;
    grant_id_d = grant_id_q;
    din_d      = din_q;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = StLaunch;
          cnt_d      = '0;
          din_d      = cand_data;
          grant_id_d = cand_idx;
          if (cand_last) begin
            lock_d = 1'b0;
            ptr_d  = IdxW'(wrap_inc(32'(cand_idx), N_REQ));
          end else begin
            lock_d    = 1'b1;
            lock_id_d = cand_idx;
          end
        end
      end
      StLaunch: begin
        if (uart_tx_busy) begin
          state_d = StWaitDone;
        end else if (cnt_q == LaunchLast) begin
          // uart_send never answered: drop the byte and break any packet lock.
          err_d   = 1'b1;
          lock_d  = 1'b0;
          ptr_d   = IdxW'(wrap_inc(32'(grant_id_q), N_REQ));
          cnt_d   = '0;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitDone: begin
        if (!uart_tx_busy) begin
          cnt_d   = '0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) state_d = StIdle;
        else                  cnt_d   = cnt_q + CntW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    uart_en   = (state_q == StLaunch);
    req_ready = '0;
    if (state_q == StIdle && !uart_tx_busy) req_ready = cand_oh;
  end

  assign uart_din    = din_q;
  assign grant_id    = grant_id_q;
  assign arb_busy    = (state_q != StIdle);
  assign err_timeout = err_q;

endmodule
